// File: rtl/mips_pkg.sv
// Shared SimpleMIPS definitions: instruction width and the loader state encoding.
// The enum is exported so benches can probe the loader state by name.
package mips_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Streams instruction words into imem from address 0; write lands 1 cycle after the transfer edge.
// in_ready is high only while loading, so the source simply stalls otherwise; the CPU is held until DONE.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = INSTR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic [DATA_W-1:0] checksum
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              run_q, run_d;

  // The word count doubles as the write pointer; its top bit only sets on the final slot.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    run_d   = 1'b0;
    if (start) begin
      state_d = LOAD;
      count_d = '0;
      sum_d   = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (in_valid) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = in_data;
            count_d = count_q + 1'b1;
            sum_d   = sum_q + in_data;
            if (in_last) begin
              state_d = DONE;
            end else if (&count_q[ADDR_W-1:0]) begin
              state_d = ERR;
            end
          end
        end
        DONE:    run_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign load_done  = (state_q == DONE);
  assign overflow   = (state_q == ERR);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_run    = run_q;
  assign word_count = count_q;
  assign checksum   = sum_q;

endmodule
